// File: rtl/sprite_arb_pkg.sv
// Shared constants and types for the sprite ROM arbiter and its picker.
// Tags are sized for the largest supported requester count.
package sprite_arb_pkg;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 5;
    localparam int DEF_DEPTH   = 3600;
    localparam int MAX_NUM_REQ = 8;
    localparam int TAG_W       = $clog2(MAX_NUM_REQ);

    typedef logic [DEF_ADDR_W-1:0] sprite_addr_t;
    typedef logic [DEF_DATA_W-1:0] pix_idx_t;
    typedef logic [TAG_W-1:0]      arb_tag_t;

    function automatic arb_tag_t tag_wrap_inc(arb_tag_t t, int n);
        return (int'(t) + 1 >= n) ? '0 : arb_tag_t'(t + 1'b1);
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest request at or above ptr wins,
// otherwise the lowest request overall (wrap-around search).
module rr_pick
    import sprite_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  arb_tag_t     ptr,
    output logic [N-1:0] gnt,
    output arb_tag_t     idx,
    output logic         any
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] src;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        src = ((req & hi_mask) != '0) ? (req & hi_mask) : req;
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (src[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = arb_tag_t'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM; 2-cycle latency.
// Define SPRITE_ARB_LOCK_EN to add the per-requester burst lock input.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
`ifdef SPRITE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    logic [NUM_REQ-1:0] pick_gnt;
    arb_tag_t           pick_idx;
    logic               pick_any;

    logic [NUM_REQ-1:0] win_gnt;
    arb_tag_t           win_idx;
    logic               win_any;
    logic               hold;
    logic [ADDR_W-1:0]  win_addr;

    arb_tag_t          ptr_q, ptr_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              s1_valid_q, s1_valid_d;
    arb_tag_t          s1_tag_q, s1_tag_d;
    logic              s1_oor_q, s1_oor_d;
    logic              s2_valid_q, s2_valid_d;
    arb_tag_t          s2_tag_q, s2_tag_d;
    logic              s2_oor_q, s2_oor_d;

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req(req),
        .ptr(ptr_q),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

`ifdef SPRITE_ARB_LOCK_EN
    // s1 holds last cycle's grant, so it names the burst owner.
    logic [NUM_REQ-1:0] last_oh;

    always_comb begin
        last_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            last_oh[i] = s1_valid_q && (s1_tag_q == arb_tag_t'(i));
        end
        hold    = |(last_oh & req & lock);
        win_gnt = hold ? last_oh : pick_gnt;
        win_idx = hold ? s1_tag_q : pick_idx;
        win_any = hold | pick_any;
    end
`else
    assign hold    = 1'b0;
    assign win_gnt = pick_gnt;
    assign win_idx = pick_idx;
    assign win_any = pick_any;
`endif

    assign gnt = Reset ? '0 : win_gnt;

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end

        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        s1_valid_d = win_any;
        s1_tag_d   = win_idx;
        s1_oor_d   = 1'b0;
        if (win_any) begin
            s1_oor_d   = int'(win_addr) >= DEPTH;
            rom_addr_d = s1_oor_d ? '0 : win_addr;
            if (!hold) begin
                ptr_d = tag_wrap_inc(win_idx, NUM_REQ);
            end
        end

        s2_valid_d = s1_valid_q;
        s2_tag_d   = s1_tag_q;
        s2_oor_d   = s1_oor_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s1_oor_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_oor_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_oor_q   <= s1_oor_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            s2_oor_q   <= s2_oor_d;
        end
    end

    assign rom_addr = rom_addr_q;

    // s2 lines up with rom_data, which lags rom_addr by one clock.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = s2_valid_q && (s2_tag_q == arb_tag_t'(i));
        end
        rsp_data = (s2_valid_q && !s2_oor_q) ? rom_data : '0;
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: scenario tasks plus a
// queue-based reference model of grants and 2-cycle-late responses.
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;

    localparam int N     = 4;
    localparam int AW    = 12;
    localparam int DW    = 5;
    localparam int DEPTH = 3600;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
`ifdef SPRITE_ARB_LOCK_EN
    logic [N-1:0]    lock;
`endif
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;

    logic [DW-1:0] mem [0:4095];

    sprite_rom_arbiter dut (
        .Clk(Clk),
        .Reset(Reset),
        .req(req),
        .req_addr(req_addr),
`ifdef SPRITE_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= mem[rom_addr];

    typedef struct {
        int            due;
        int            tag;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          q[$];
    int            ptr, cyc, last_idx, exp_idx;
    bit            last_v, exp_locked;
    logic [N-1:0]  exp_gnt, exp_rv;
    logic [DW-1:0] exp_rd;
    int            total = 0;
    int            bad = 0;

    task automatic model_clear();
        q.delete();
        ptr    = 0;
        last_v = 0;
    endtask

    task automatic predict();
        int j;
        exp_gnt    = '0;
        exp_idx    = -1;
        exp_locked = 0;
        if (!Reset) begin
`ifdef SPRITE_ARB_LOCK_EN
            if (last_v && req[last_idx] && lock[last_idx]) begin
                exp_idx    = last_idx;
                exp_locked = 1;
            end
`endif
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (exp_idx < 0 && req[j]) exp_idx = j;
            end
            if (exp_idx >= 0) exp_gnt[exp_idx] = 1'b1;
        end
        exp_rv = '0;
        exp_rd = '0;
        if (!Reset && q.size() > 0 && q[0].due == cyc) begin
            exp_rv[q[0].tag] = 1'b1;
            exp_rd           = q[0].data;
        end
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic advance();
        int   a;
        rsp_t r;
        if (Reset) begin
            model_clear();
        end else begin
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (exp_idx >= 0) begin
                a      = int'(req_addr[exp_idx*AW +: AW]);
                r.due  = cyc + 2;
                r.tag  = exp_idx;
                r.data = (a >= DEPTH) ? '0 : mem[a];
                q.push_back(r);
                if (!exp_locked) ptr = (exp_idx + 1) % N;
                last_v   = 1;
                last_idx = exp_idx;
            end else begin
                last_v = 0;
            end
        end
        @(posedge Clk);
        @(negedge Clk);
        cyc++;
    endtask

    task automatic set_addr(int i, int a);
        req_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        req   = '1;
        req_addr = '0;
`ifdef SPRITE_ARB_LOCK_EN
        lock = '0;
`endif
        repeat (2) @(negedge Clk);
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL reset_gnt got=%b exp=0000", gnt);
        end
        total++;
        if (rom_addr !== 12'h000) begin
            bad++;
            $display("FAIL reset_rom_addr got=%h exp=000", rom_addr);
        end
        total++;
        if (rsp_valid !== 4'b0000) begin
            bad++;
            $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid);
        end
        req   = '0;
        Reset = 1'b0;
        model_clear();
        cyc = 0;
    endtask

    task automatic test_rotation();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        req = '1;
        for (int i = 0; i < N; i++) set_addr(i, $urandom_range(DEPTH - 1));
        for (int c = 0; c < 9; c++) begin
            if (c == 6) req = '0;
            settle();
            total++;
            if (c < 6 && gnt !== 4'(1 << seq[c])) begin
                bad++;
                $display("FAIL rot_order c=%0d got=%b exp=%b", c, gnt, 4'(1 << seq[c]));
            end
            total++;
            if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
                bad++;
                $display("FAIL rot_rsp c=%0d got=%b/%h exp=%b/%h",
                         c, rsp_valid, rsp_data, exp_rv, exp_rd);
            end
            advance();
            if (c < 6) set_addr(seq[c], $urandom_range(DEPTH - 1));
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        set_addr(2, 5);
        settle();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL single_gnt got=%b exp=0100", gnt);
        end
        advance();
        req = '0;
        settle();
        total++;
        if (rom_addr !== 12'h005) begin
            bad++;
            $display("FAIL single_rom_addr got=%h exp=005", rom_addr);
        end
        advance();
        settle();
        total++;
        if (rsp_valid !== 4'b0100 || rsp_data !== mem[5] || exp_rd !== mem[5]) begin
            bad++;
            $display("FAIL single_rsp got=%b/%h exp=0100/%h", rsp_valid, rsp_data, mem[5]);
        end
        advance();
    endtask

    task automatic test_out_of_range();
        req = 4'b0010;
        set_addr(1, 12'hE10);
        settle();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL oor_gnt got=%b exp=0010", gnt);
        end
        advance();
        req = '0;
        settle();
        total++;
        if (rom_addr !== 12'h000) begin
            bad++;
            $display("FAIL oor_rom_addr got=%h exp=000", rom_addr);
        end
        advance();
        settle();
        total++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 5'd0) begin
            bad++;
            $display("FAIL oor_rsp got=%b/%h exp=0010/00", rsp_valid, rsp_data);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        req = 4'b0011;
        set_addr(0, 100);
        set_addr(1, 200);
        for (int c = 0; c < 2; c++) begin
            settle();
            advance();
            req[exp_idx] = 1'b0;
        end
        Reset = 1'b1;
        req   = '0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) Reset = 1'b0;
            settle();
            total++;
            if (rsp_valid !== 4'b0000 || gnt !== 4'b0000) begin
                bad++;
                $display("FAIL rstmid_quiet c=%0d got=%b/%b exp=0000/0000", c, rsp_valid, gnt);
            end
            advance();
        end
        req = 4'b1000;
        set_addr(3, 300);
        settle();
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL rstmid_first got=%b exp=1000", gnt);
        end
        advance();
        req = 4'b1001;
        set_addr(0, 400);
        settle();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_ptr0 got=%b exp=0001", gnt);
        end
        advance();
        req = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++;
            if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
                bad++;
                $display("FAIL rstmid_rsp c=%0d got=%b/%h exp=%b/%h",
                         c, rsp_valid, rsp_data, exp_rv, exp_rd);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) set_addr(0, 10 + c);
            if (c == 3) req = '0;
            settle();
            if (c < 3) begin
                total++;
                if (gnt !== 4'b0001) begin
                    bad++;
                    $display("FAIL b2b_gnt c=%0d got=%b exp=0001", c, gnt);
                end
            end else begin
                total++;
                if (rom_addr !== 12'd12) begin
                    bad++;
                    $display("FAIL b2b_addr_hold c=%0d got=%h exp=00c", c, rom_addr);
                end
            end
            if (c >= 2) begin
                total++;
                if (rsp_valid !== 4'b0001 || rsp_data !== mem[10 + c - 2]) begin
                    bad++;
                    $display("FAIL b2b_rsp c=%0d got=%b/%h exp=0001/%h",
                             c, rsp_valid, rsp_data, mem[10 + c - 2]);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'($urandom_range(1));
            set_addr(i, ($urandom_range(9) == 0) ? $urandom_range(4095, DEPTH)
                                                  : $urandom_range(DEPTH - 1));
        end
        for (int c = 0; c < 400; c++) begin
            if (c >= 397) req = '0;
            settle();
            total++;
            if (gnt !== exp_gnt || $countones(gnt) > 1) begin
                bad++;
                $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt);
            end
            total++;
            if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
                bad++;
                $display("FAIL rand_rsp c=%0d got=%b/%h exp=%b/%h",
                         c, rsp_valid, rsp_data, exp_rv, exp_rd);
            end
            g = exp_idx;
            advance();
            for (int i = 0; i < N; i++) begin
                if (!req[i] || i == g) begin
                    req[i] = 1'($urandom_range(1));
                    set_addr(i, ($urandom_range(9) == 0) ? $urandom_range(4095, DEPTH)
                                                          : $urandom_range(DEPTH - 1));
                end
            end
        end
    endtask

`ifdef SPRITE_ARB_LOCK_EN
    task automatic test_lock();
        req = 4'b0001;
        set_addr(0, 50);
        settle();
        advance();
        req  = 4'b0111;
        lock = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) lock = '0;
            settle();
            total++;
            if (gnt !== ((c < 4) ? 4'b0010 : 4'b0100) || gnt !== exp_gnt) begin
                bad++;
                $display("FAIL lock_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt);
            end
            advance();
        end
        req = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++;
            if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
                bad++;
                $display("FAIL lock_rsp c=%0d got=%b/%h exp=%b/%h",
                         c, rsp_valid, rsp_data, exp_rv, exp_rd);
            end
            advance();
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
        test_reset();
        test_rotation();
        test_single();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
`ifdef SPRITE_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port synchronous sprite ROM between several requesters, e.g. score digits, countdown and HUD icon drawers in the VGA path.
- The ROM is one word wide (5-bit palette index) with a registered read: one clock of latency from address to data.
- The block grants one requester per cycle using round-robin, registers the granted address and returns the ROM data to that requester with a one-hot response strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 12, ROM address width.
- DATA_W, 5, ROM data width (palette index).
- DEPTH, 3600, valid ROM words; addresses >= DEPTH are out of range.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester read request, level.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- rom_addr  out  ADDR_W  registered address to the ROM read port.
- rom_data  in  DATA_W  ROM output, valid one cycle after rom_addr.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_data  out  DATA_W  response data.

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-high.
- Reset values: rom_addr=0; rsp_valid=0; round-robin pointer=0; pipeline valid/tag/oor registers=0. gnt is combinational and stays 0 while Reset is high.
- Arbitration (cycle N):
  - gnt[i]=1 for the first i with req[i]=1, searching from pointer upward with wrap.
  - At most one gnt bit is high; gnt=0 when req=0.
- Requester rule: hold req and req_addr stable until gnt is seen; a granted request is consumed at the edge ending cycle N. To issue back-to-back reads, keep req high and update the address after each grant.
- Pointer update: on any grant to i, pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Stage 1 (edge ending N):
  - rom_addr <= granted address, or 0 if out of range.
  - s1_valid, s1_tag (index i) and s1_oor (address >= DEPTH) are registered.
  - rom_addr holds its value when there is no grant.
- Stage 2 (edge ending N+1): s2_valid, s2_tag and s2_oor are registered, aligned with rom_data.
- Response (cycle N+2):
  - rsp_valid[s2_tag]=s2_valid.
  - rsp_data=0 if s2_oor, else rom_data; 0 when not valid.
  - Total latency from grant to response is 2 cycles; throughput is 1 read per cycle.
- Response ordering: responses return in grant order, and each requester sees its responses in issue order.
- Simultaneous requests: all NUM_REQ requesters held high are each granted once every NUM_REQ cycles, in strict rotation.
- Reset mid-operation: in-flight stages are discarded immediately, no rsp_valid is produced for them and the pointer returns to 0.
- No backpressure on responses: requesters must accept rsp_valid whenever it occurs.

Optional Feature:
- Macro: SPRITE_ARB_LOCK_EN. It adds an input port lock (NUM_REQ bits).
- With the macro defined: while the requester granted in the previous cycle keeps req and lock high, it wins again regardless of the pointer. This gives burst fetch of a sprite row, and the pointer is not advanced during the lock. Releasing lock or req ends the burst, and normal round-robin resumes from that requester+1.
- Without the macro: no lock port, pure round-robin.

Decomposition:
- Package sprite_arb_pkg holds:
  - ADDR_W, DATA_W, DEPTH defaults;
  - the max NUM_REQ constant;
  - typedef sprite_addr_t (logic [ADDR_W-1:0]);
  - typedef pix_idx_t (logic [DATA_W-1:0]);
  - a tag typedef sized $clog2(NUM_REQ).
- One sub-module, rr_pick: combinational round-robin one-hot picker (req vector + pointer -> grant and index). It is reused by later arbiters.

Test Plan:
- Single requester: req[2]=1, addr=0x005 at cycle 0 -> gnt=0100 in cycle 0; rom_addr=0x005 in cycle 1; rsp_valid=0100 and rsp_data=mem[5] in cycle 2.
- All four req held high from reset -> grants 0,1,2,3,0,1 on consecutive cycles; each response arrives 2 cycles after its grant with the matching tag.
- Out of range: req[1], addr=0xE10 (3600) -> rom_addr=0; rsp_valid=0010 and rsp_data=0 two cycles later.
- Reset asserted the cycle after two grants -> rsp_valid stays 0 throughout. After release, req[3] alone is granted first; then req[0]+req[3] from pointer 0 -> req[0] granted first.
- Back-to-back: req[0] held with addresses 10,11,12 over 3 cycles -> three consecutive responses mem[10..12], in order.
- SPRITE_ARB_LOCK_EN: req[1]+lock[1] high for 4 cycles with req[0],req[2] also high -> gnt[1] for 4 cycles. After lock drops, next grant goes to requester 2.
